demod_conj: RTL and testbench

DEMOD_CONJ -- requirements
Module: demod_conj

---
 rtl/demod_conj.sv | 127 ++++++++++++
 tb/tb_demod_conj.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/demod_conj.sv
// demod_conj: conjugate-product stage of an FM demodulator.
//
// Pops one complex sample (i_in, q_in) from a first-word-fall-through FIFO,
// multiplies it by the conjugate of the previous sample, dequantizes the
// products and hands the result (x = real part, y = imaginary part) to a
// downstream arctan stage. After each result it waits for the arctan stage
// to report completion before it accepts the next sample.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   i_in, q_in   in   signed 32-bit sample, valid while in_empty = 0
//   in_empty     in   upstream FIFO empty flag
//   in_rd_en     out  one-cycle FIFO pop (combinational, IDLE only)
//   arctan_valid in   arctan stage done; releases the block for a new sample
//   x, y         out  signed 32-bit conjugate product (registered)
//   start        out  one-cycle pulse, x/y valid for the arctan stage
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a sample; pops and captures it when in_empty = 0
// MULT  | registers the four cross products with the previous sample
// SUM   | dequantizes and combines the products into x and y
// ISSUE | start pulse; current sample becomes the previous sample
// WAIT  | holds x/y until arctan_valid returns
module demod_conj #(
  parameter int QUANT_BITS = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [31:0] i_in,
  input  logic signed [31:0] q_in,
  input  logic               in_empty,
  output logic               in_rd_en,
  input  logic               arctan_valid,
  output logic signed [31:0] x,
  output logic signed [31:0] y,
  output logic               start
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MULT  = 3'd1,
    S_SUM   = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  // Added to negative products before the arithmetic shift so the shift
  // rounds toward zero instead of toward minus infinity.
  localparam logic signed [63:0] DEQ_BIAS = (64'sd1 <<< QUANT_BITS) - 64'sd1;

  state_t             r_state;
  logic signed [31:0] r_cur_i;
  logic signed [31:0] r_cur_q;
  logic signed [31:0] r_prev_i;
  logic signed [31:0] r_prev_q;
  logic signed [63:0] r_p_ii;
  logic signed [63:0] r_p_qq;
  logic signed [63:0] r_p_qi;
  logic signed [63:0] r_p_iq;

  logic               w_pop;

  function automatic logic signed [31:0] deq(input logic signed [63:0] p);
    logic signed [63:0] t;
    t = p + (p[63] ? DEQ_BIAS : 64'sd0);
    t = t >>> QUANT_BITS;
    return t[31:0];
  endfunction

  // Gated by reset so the pop stays low while reset is held, even though
  // the state register already reads IDLE.
  assign w_pop    = reset && (r_state == S_IDLE) && !in_empty;
  assign in_rd_en = w_pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cur_i  <= '0;
      r_cur_q  <= '0;
      r_prev_i <= '0;
      r_prev_q <= '0;
      r_p_ii   <= '0;
      r_p_qq   <= '0;
      r_p_qi   <= '0;
      r_p_iq   <= '0;
      x        <= '0;
      y        <= '0;
      start    <= 1'b0;
    end else begin
      start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_cur_i <= i_in;
            r_cur_q <= q_in;
            r_state <= S_MULT;
          end
        end
        S_MULT: begin
          r_p_ii  <= 64'(r_cur_i) * 64'(r_prev_i);
          r_p_qq  <= 64'(r_cur_q) * 64'(r_prev_q);
          r_p_qi  <= 64'(r_cur_q) * 64'(r_prev_i);
          r_p_iq  <= 64'(r_cur_i) * 64'(r_prev_q);
          r_state <= S_MULT == r_state ? S_SUM : S_IDLE;
        end
        S_SUM: begin
          x       <= deq(r_p_ii) + deq(r_p_qq);
          y       <= deq(r_p_qi) - deq(r_p_iq);
          start   <= 1'b1;  // lands in the ISSUE cycle
          r_state <= S_ISSUE;
        end
        S_ISSUE: begin
          r_prev_i <= r_cur_i;
          r_prev_q <= r_cur_q;
          r_state  <= arctan_valid ? S_IDLE : S_WAIT;
        end
        S_WAIT: begin
          if (arctan_valid) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_demod_conj.sv
// Directed testbench for demod_conj (QUANT_BITS = 10).
module tb_demod_conj;

  logic               clk;
  logic               reset;
  logic signed [31:0] i_in;
  logic signed [31:0] q_in;
  logic               in_empty;
  logic               in_rd_en;
  logic               arctan_valid;
  logic signed [31:0] x;
  logic signed [31:0] y;
  logic               start;

  int n_checks;
  int n_fail;

  demod_conj #(.QUANT_BITS(10)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_in         (i_in),
    .q_in         (q_in),
    .in_empty     (in_empty),
    .in_rd_en     (in_rd_en),
    .arctan_valid (arctan_valid),
    .x            (x),
    .y            (y),
    .start        (start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a sample while in IDLE and confirm the combinational pop.
  task automatic push(input logic [31:0] ii, input logic [31:0] qq, input string tag);
    i_in     = ii;
    q_in     = qq;
    in_empty = 1'b0;
    #1;
    check({tag, " rd_en at pop"}, 32'(in_rd_en), 32'd1);
  endtask

  // Follow a sample from the pop edge through ISSUE; optionally return
  // arctan_valid in the ISSUE cycle.
  task automatic finish_sample(input bit ack, input logic [31:0] ex,
                               input logic [31:0] ey, input string tag);
    @(posedge clk); #1;
    in_empty = 1'b1;
    #1;
    check({tag, " rd_en MULT"}, 32'(in_rd_en), 32'd0);
    check({tag, " start MULT"}, 32'(start), 32'd0);
    @(posedge clk); #2;
    check({tag, " start SUM"}, 32'(start), 32'd0);
    @(posedge clk); #1;
    if (ack) arctan_valid = 1'b1;
    #1;
    check({tag, " start ISSUE"}, 32'(start), 32'd1);
    check({tag, " x"}, x, ex);
    check({tag, " y"}, y, ey);
    check({tag, " rd_en ISSUE"}, 32'(in_rd_en), 32'd0);
    @(posedge clk); #1;
    arctan_valid = 1'b0;
    #1;
    check({tag, " start after"}, 32'(start), 32'd0);
  endtask

  initial begin
    int n_rd;
    int n_st;
    logic [31:0] cap_x;
    logic [31:0] cap_y;
    n_checks     = 0;
    n_fail       = 0;
    reset        = 1'b0;
    in_empty     = 1'b1;
    arctan_valid = 1'b0;
    i_in         = '0;
    q_in         = '0;
    cap_x        = '0;
    cap_y        = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset x", x, 32'd0);
    check("reset y", y, 32'd0);
    check("reset start", 32'(start), 32'd0);
    check("reset rd_en", 32'(in_rd_en), 32'd0);
    reset = 1'b1;
    @(posedge clk); #2;
    check("idle empty rd_en", 32'(in_rd_en), 32'd0);

    // First sample after reset: prev is zero.
    push(32'h0000_0400, 32'h0, "s1");
    finish_sample(1'b1, 32'h0, 32'h0, "s1");
    // prev=(0x400,0), cur=(0,0x400): y = 0x400*0x400/1024.
    push(32'h0, 32'h0000_0400, "s2");
    finish_sample(1'b1, 32'h0, 32'h0000_0400, "s2");
    // Need prev=(0x400,0) for the truncation pair.
    push(32'h0000_0400, 32'h0, "s3");
    finish_sample(1'b1, 32'h0, 32'hFFFF_FC00, "s3");
    // cur=(-1,0), prev=(0x400,0): -1024/1024 = -1.
    push(32'hFFFF_FFFF, 32'h0, "trunc_a");
    finish_sample(1'b1, 32'hFFFF_FFFF, 32'h0, "trunc_a");
    // cur=(1,0), prev=(-1,0): DEQ(-1) truncates to 0.
    push(32'h0000_0001, 32'h0, "trunc_b");
    finish_sample(1'b1, 32'h0, 32'h0, "trunc_b");

    // Backpressure: A=(3000,-2000) with prev=(1,0) -> x=2, y=DEQ(-2000)=-1.
    push(32'd3000, -32'sd2000, "bp_a");
    @(posedge clk); #1;
    i_in = 32'h0000_0800;   // B becomes the FIFO head, still not empty
    q_in = 32'h0000_0400;
    n_rd = 0;
    n_st = 0;
    for (int k = 0; k < 22; k++) begin
      #1;
      if (in_rd_en) n_rd++;
      if (start) begin
        n_st++;
        cap_x = x;
        cap_y = y;
      end
      @(posedge clk); #1;
    end
    check("bp extra pops", 32'(n_rd), 32'd0);
    check("bp starts", 32'(n_st), 32'd1);
    check("bp x", cap_x, 32'd2);
    check("bp y", cap_y, 32'hFFFF_FFFF);
    check("bp x held", x, 32'd2);
    check("bp y held", y, 32'hFFFF_FFFF);
    arctan_valid = 1'b1;
    #1;
    check("bp rd_en on ack", 32'(in_rd_en), 32'd0);
    @(posedge clk); #1;
    arctan_valid = 1'b0;
    #1;
    check("bp rd_en after ack", 32'(in_rd_en), 32'd1);
    // B=(0x800,0x400), prev=(3000,-2000): x=6000-2000, y=3000+4000.
    finish_sample(1'b1, 32'd4000, 32'd7000, "bp_b");

    // Empty stall.
    n_rd = 0;
    n_st = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #2;
      if (in_rd_en) n_rd++;
      if (start) n_st++;
    end
    check("stall rd_en", 32'(n_rd), 32'd0);
    check("stall start", 32'(n_st), 32'd0);
    check("stall x", x, 32'd4000);
    check("stall y", y, 32'd7000);

    // Reset while in WAIT. C=(5,5), prev=(0x800,0x400): x=10+5, y=10-5.
    push(32'd5, 32'd5, "c");
    finish_sample(1'b0, 32'd15, 32'd5, "c");
    @(posedge clk); #2;
    check("wait x", x, 32'd15);
    i_in     = 32'h0000_0400;
    q_in     = 32'h0000_0400;
    in_empty = 1'b0;
    #1;
    check("wait rd_en", 32'(in_rd_en), 32'd0);
    reset = 1'b0;
    #1;
    check("rst wait start", 32'(start), 32'd0);
    check("rst wait rd_en", 32'(in_rd_en), 32'd0);
    check("rst wait x", x, 32'd0);
    check("rst wait y", y, 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("post rst rd_en", 32'(in_rd_en), 32'd1);
    finish_sample(1'b1, 32'h0, 32'h0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
